// File: rtl/maxpool_stream_kxk.sv
// maxpool_stream_kxk: streaming, channel-parallel, non-overlapping KxK max-pool
// over sign-magnitude (FP16-style) pixels arriving one per beat in raster order.
// Per-bin partial maxima live in registers; results leave through a one-entry
// registered output stage with valid/ready flow control.
// Optional feature: define MAXPOOL_RELU_EN to clamp negative results (including
// -0) to all-zeros at the output register.
module maxpool_stream_kxk #(
   parameter int DATA_WIDTH = 16,
   parameter int D          = 2,
   parameter int H          = 9,
   parameter int W          = 9,
   parameter int K          = 9
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [D*DATA_WIDTH-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [D*DATA_WIDTH-1:0] out_data,
   output logic                    out_last
);

   localparam int NB = W / K;
   localparam int RW = (H  > 1) ? $clog2(H)  : 1;
   localparam int CW = (W  > 1) ? $clog2(W)  : 1;
   localparam int KW = (K  > 1) ? $clog2(K)  : 1;
   localparam int JW = (NB > 1) ? $clog2(NB) : 1;

   // Input beats the positive-vs-negative comparison when it is strictly larger;
   // the sign decides first, so +0 overtakes a -0 accumulator.
   function automatic logic in_wins(input logic [DATA_WIDTH-1:0] a,
                                    input logic [DATA_WIDTH-1:0] b);
      logic sa;
      logic sb;
      logic [DATA_WIDTH-2:0] ma;
      logic [DATA_WIDTH-2:0] mb;
      sa = a[DATA_WIDTH-1];
      sb = b[DATA_WIDTH-1];
      ma = a[DATA_WIDTH-2:0];
      mb = b[DATA_WIDTH-2:0];
      if (sa != sb) return sa;
      else if (!sa)  return (mb > ma);
      else           return (mb < ma);
   endfunction

   // Sign-magnitude max; accumulator (a) is kept on ties.
   function automatic logic [DATA_WIDTH-1:0] sm_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
      return in_wins(a, b) ? b : a;
   endfunction

   // Output-stage activation: optional fused ReLU.
   function automatic logic [DATA_WIDTH-1:0] out_act(input logic [DATA_WIDTH-1:0] x);
`ifdef MAXPOOL_RELU_EN
      return x[DATA_WIDTH-1] ? '0 : x;
`else
      return x;
`endif
   endfunction

   logic [RW-1:0] r_q,  r_d;
   logic [CW-1:0] c_q,  c_d;
   logic [KW-1:0] pr_q, pr_d;
   logic [KW-1:0] pc_q, pc_d;
   logic [JW-1:0] j_q,  j_d;

   logic [DATA_WIDTH-1:0] acc_q [NB][D];
   logic [DATA_WIDTH-1:0] acc_d [NB][D];

   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q,  out_last_d;
   logic [D*DATA_WIDTH-1:0] out_data_q,  out_data_d;

   logic [DATA_WIDTH-1:0] in_ch  [D];
   logic [DATA_WIDTH-1:0] sel_ch [D];
   logic [DATA_WIDTH-1:0] cur_ch [D];

   logic accept;
   logic first_beat;
   logic win_done;
   logic col_last;
   logic row_last;
   logic pc_last;
   logic pr_last;

   assign in_ready  = !out_valid_q || out_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

   // Next-state: raster counters, per-bin accumulation and output-slot update.
   always_comb begin
      accept     = in_valid && in_ready;
      col_last   = (c_q  == CW'(W - 1));
      row_last   = (r_q  == RW'(H - 1));
      pc_last    = (pc_q == KW'(K - 1));
      pr_last    = (pr_q == KW'(K - 1));
      first_beat = (pr_q == '0) && (pc_q == '0);
      win_done   = pr_last && pc_last;

      r_d         = r_q;
      c_d         = c_q;
      pr_d        = pr_q;
      pc_d        = pc_q;
      j_d         = j_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;

      // Slice channels and pick the active bin's partial maxima.
      for (int ch = 0; ch < D; ch++) begin
         in_ch[ch]  = in_data[(D-ch)*DATA_WIDTH-1 -: DATA_WIDTH];
         sel_ch[ch] = '0;
         for (int jj = 0; jj < NB; jj++) begin
            if (j_q == JW'(jj)) sel_ch[ch] = acc_q[jj][ch];
         end
         cur_ch[ch] = first_beat ? in_ch[ch] : sm_max(sel_ch[ch], in_ch[ch]);
      end

      // A consumed result frees the slot unless a new one replaces it below.
      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         for (int jj = 0; jj < NB; jj++) begin
            if (j_q == JW'(jj)) begin
               for (int ch = 0; ch < D; ch++) acc_d[jj][ch] = cur_ch[ch];
            end
         end

         if (win_done) begin
            out_valid_d = 1'b1;
            out_last_d  = row_last && col_last;
            for (int ch = 0; ch < D; ch++) begin
               out_data_d[(D-ch)*DATA_WIDTH-1 -: DATA_WIDTH] = out_act(cur_ch[ch]);
            end
         end

         // W and H are multiples of K, so the window phases wrap with the row/frame.
         if (col_last) begin
            c_d  = '0;
            j_d  = '0;
            pc_d = '0;
            pr_d = pr_last  ? '0 : pr_q + 1'b1;
            r_d  = row_last ? '0 : r_q + 1'b1;
         end else begin
            c_d = c_q + 1'b1;
            if (pc_last) begin
               pc_d = '0;
               j_d  = j_q + 1'b1;
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q         <= '0;
         c_q         <= '0;
         pr_q        <= '0;
         pc_q        <= '0;
         j_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         for (int jj = 0; jj < NB; jj++) begin
            for (int ch = 0; ch < D; ch++) acc_q[jj][ch] <= '0;
         end
      end else begin
         r_q         <= r_d;
         c_q         <= c_d;
         pr_q        <= pr_d;
         pc_q        <= pc_d;
         j_q         <= j_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         acc_q       <= acc_d;
      end
   end

endmodule

// File: tb/tb_maxpool_stream_kxk.sv
// Bench for maxpool_stream_kxk: three instances (9x9/K9/D2 spike frame,
// 4x4/K2/D1 streaming scenarios, 2x2/K2/D1 single-window comparison table).
module tb_maxpool_stream_kxk;

   logic clk;
   logic rst;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
   logic [31:0] a_in_data, a_out_data;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [15:0] b_in_data, b_out_data;
   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
   logic [15:0] c_in_data, c_out_data;

   int checks = 0;
   int errors = 0;

   logic [15:0] px_q[$];
   logic [16:0] exp_q[$];

   maxpool_stream_kxk #(.DATA_WIDTH(16), .D(2), .H(9), .W(9), .K(9)) dut_a (
      .clk(clk), .reset(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_last(a_out_last));

   maxpool_stream_kxk #(.DATA_WIDTH(16), .D(1), .H(4), .W(4), .K(2)) dut_b (
      .clk(clk), .reset(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last));

   maxpool_stream_kxk #(.DATA_WIDTH(16), .D(1), .H(2), .W(2), .K(2)) dut_c (
      .clk(clk), .reset(rst),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .out_last(c_out_last));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [15:0] relu_m(input logic [15:0] x);
`ifdef MAXPOOL_RELU_EN
      return x[15] ? 16'h0000 : x;
`else
      return x;
`endif
   endfunction

   // Total order key: +0 above -0, negatives ordered by decreasing magnitude.
   function automatic int key(input logic [15:0] v);
      return v[15] ? (-int'(v[14:0]) - 1) : int'(v[14:0]);
   endfunction

   function automatic logic [15:0] pix(input int set, input int idx);
      case (set)
         0:       return 16'h3C00 + 16'(idx);
         1:       return (idx % 3 == 0) ? (16'h8000 | 16'(idx * 256)) : (16'h2000 + 16'(idx * 17));
         2:       return 16'h7C00;
         3:       return 16'h4000 ^ 16'(idx * 37);
         4:       return 16'h5000 - 16'(idx);
         default: return 16'hC000 + 16'((idx * 7) % 16);
      endcase
   endfunction

   // Queue one 4x4 frame; optionally queue its reference pooled results.
   task automatic push_frame(input int set, input bit with_exp);
      logic [15:0] m;
      logic [15:0] v;
      for (int idx = 0; idx < 16; idx++) px_q.push_back(pix(set, idx));
      if (with_exp) begin
         for (int wr = 0; wr < 2; wr++) begin
            for (int wc = 0; wc < 2; wc++) begin
               m = pix(set, (2*wr)*4 + 2*wc);
               for (int dr = 0; dr < 2; dr++) begin
                  for (int dc = 0; dc < 2; dc++) begin
                     v = pix(set, (2*wr+dr)*4 + 2*wc + dc);
                     if (key(v) > key(m)) m = v;
                  end
               end
               exp_q.push_back({(wr == 1 && wc == 1), relu_m(m)});
            end
         end
      end
   endtask

   // Stream px_q into dut_b and score outputs against exp_q.
   task automatic run_b(input int hold_cycles, input int gap_every, input string tag);
      int cyc = 0;
      bit seen = 0;
      int hold = 0;
      logic held_v = 1'b0;
      logic [16:0] held = '0;
      while ((px_q.size() > 0 || exp_q.size() > 0) && cyc < 400) begin
         @(negedge clk);
         if (!seen && b_out_valid && hold_cycles > 0) begin
            seen = 1;
            hold = hold_cycles;
         end
         b_out_ready = (hold == 0);
         if (hold > 0) hold--;
         if (px_q.size() > 0 && !(gap_every > 0 && (cyc % gap_every) == gap_every - 1)) begin
            b_in_valid = 1'b1;
            b_in_data  = px_q[0];
         end else begin
            b_in_valid = 1'b0;
            b_in_data  = 16'h7FFF;
         end
         #1;
         chk({tag, "_in_ready"}, b_in_ready, (!b_out_valid || b_out_ready));
         if (held_v && b_out_valid) chk({tag, "_held_stable"}, {b_out_last, b_out_data}, held);
         held_v = b_out_valid && !b_out_ready;
         held   = {b_out_last, b_out_data};
         if (b_out_valid && b_out_ready) begin
            if (exp_q.size() == 0) chk({tag, "_extra_output"}, {b_out_last, b_out_data}, 17'h1FFFF);
            else chk({tag, "_result"}, {b_out_last, b_out_data}, exp_q.pop_front());
         end
         if (b_in_valid && b_in_ready) void'(px_q.pop_front());
         cyc++;
      end
      chk({tag, "_leftover"}, px_q.size() + exp_q.size(), 0);
      px_q.delete();
      exp_q.delete();
      @(negedge clk);
      b_in_valid  = 1'b0;
      b_in_data   = 16'h7FFF;
      b_out_ready = 1'b1;
      #1;
      chk({tag, "_idle_after"}, b_out_valid, 1'b0);
   endtask

   typedef struct packed {
      logic [15:0] p0;
      logic [15:0] p1;
      logic [15:0] p2;
      logic [15:0] p3;
      logic        gap;
      logic [15:0] res;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int early;
      logic [15:0] pw[4];

      vecs[0] = '{16'hC000, 16'hBC00, 16'hC200, 16'hC400, 1'b0, 16'hBC00};
      vecs[1] = '{16'h8000, 16'h0000, 16'h8000, 16'h8000, 1'b0, 16'h0000};
      vecs[2] = '{16'h3C00, 16'h4000, 16'h3800, 16'h3E00, 1'b0, 16'h4000};
      vecs[3] = '{16'h0000, 16'h8000, 16'h8001, 16'h8000, 1'b1, 16'h0000};
      vecs[4] = '{16'hBC00, 16'h3C00, 16'hBC00, 16'hBC00, 1'b0, 16'h3C00};
      vecs[5] = '{16'h7E00, 16'h7C00, 16'h4000, 16'hFE00, 1'b0, 16'h7E00};
      vecs[6] = '{16'hFC00, 16'hFE00, 16'hFC01, 16'hFC00, 1'b1, 16'hFC00};
      vecs[7] = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b0, 16'h1234};
      vecs[8] = '{16'h8001, 16'h8002, 16'h8003, 16'h8004, 1'b0, 16'h8001};

      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_a_out_valid", a_out_valid, 1'b0);
      chk("rst_a_in_ready",  a_in_ready,  1'b1);
      chk("rst_a_out_data",  a_out_data,  32'h0);
      chk("rst_a_out_last",  a_out_last,  1'b0);
      chk("rst_b_out_valid", b_out_valid, 1'b0);
      chk("rst_b_in_ready",  b_in_ready,  1'b1);
      chk("rst_c_out_valid", c_out_valid, 1'b0);
      rst = 1'b0;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      c_out_ready = 1'b1;

      // Single 9x9 frame with one spike per channel.
      early = 0;
      for (int k = 0; k < 81; k++) begin
         @(negedge clk);
         if (a_out_valid) early++;
         a_in_valid = 1'b1;
         a_in_data  = {((k / 9 == 4 && k % 9 == 4) ? 16'h4500 : 16'h4000),
                       ((k / 9 == 8 && k % 9 == 8) ? 16'h4200 : 16'h4000)};
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_data  = 32'h7FFF_7FFF;
      #1;
      chk("spike_early_output", early, 0);
      chk("spike_out_valid", a_out_valid, 1'b1);
      chk("spike_out_data",  a_out_data,  32'h4500_4200);
      chk("spike_out_last",  a_out_last,  1'b1);
      @(negedge clk);
      #1;
      chk("spike_single_output", a_out_valid, 1'b0);

      // Single-window comparison table.
      for (int v = 0; v < 9; v++) begin
         pw[0] = vecs[v].p0; pw[1] = vecs[v].p1; pw[2] = vecs[v].p2; pw[3] = vecs[v].p3;
         for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            c_in_valid = 1'b1;
            c_in_data  = pw[b];
            if (vecs[v].gap && b == 2) begin
               c_in_valid = 1'b0;
               c_in_data  = 16'h7FFF;
               @(negedge clk);
               c_in_valid = 1'b1;
               c_in_data  = pw[b];
            end
         end
         @(negedge clk);
         c_in_valid = 1'b0;
         c_in_data  = 16'h7FFF;
         #1;
         chk($sformatf("vec%0d_out_valid", v), c_out_valid, 1'b1);
         chk($sformatf("vec%0d_out_data", v),  c_out_data,  relu_m(vecs[v].res));
         chk($sformatf("vec%0d_out_last", v),  c_out_last,  1'b1);
      end

      // Multi-window ordering with hand-computed results.
      push_frame(0, 1'b0);
      exp_q.push_back({1'b0, 16'h3C05});
      exp_q.push_back({1'b0, 16'h3C07});
      exp_q.push_back({1'b0, 16'h3C0D});
      exp_q.push_back({1'b1, 16'h3C0F});
      run_b(0, 0, "order");

      // Backpressure: consumer stalls 10 cycles at the first result.
      push_frame(1, 1'b1);
      run_b(10, 0, "bp");

      // Input bubbles carrying junk data.
      push_frame(3, 1'b1);
      run_b(0, 3, "gaps");

      // Reset after 6 beats of large values; a pending result must be dropped.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         b_in_valid = 1'b1;
         b_in_data  = pix(2, k);
      end
      @(negedge clk);
      b_in_valid  = 1'b0;
      b_in_data   = 16'h7FFF;
      b_out_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_pending", b_out_valid, 1'b1);
      @(negedge clk);
      #1;
      chk("rst_mid_out_valid", b_out_valid, 1'b0);
      chk("rst_mid_in_ready",  b_in_ready,  1'b1);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_mid_after", b_out_valid, 1'b0);
      push_frame(3, 1'b1);
      run_b(0, 0, "post_rst");

      // Back-to-back frames, positive then all-negative.
      push_frame(4, 1'b1);
      push_frame(5, 1'b1);
      run_b(0, 0, "b2b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
